mult_16_signed_accum: RTL and testbench
=======================================

// Module: mult_16_signed_accum
// PURPOSE
//  Downstream stage of the mult_16_signed chain: consumes signed 32-bit products over a valid/ready stream.
//  Accumulates them into a wide signed sum over a burst terminated by in_last.
//  Presents the burst total plus beat count on a registered valid/ready output.
//  Forms the MAC back-end for dot-product testcases.
// PARAMETERS
//  PROD_W   32  width of signed product input; must match multiplier output
//  ACC_W    40  accumulator/result width, signed; ACC_W >= PROD_W
//  CNT_W     8  beat counter width
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       product beat valid
//  in_ready   out  1       stage can accept a beat
//  in_data    in   PROD_W  signed product
//  in_last    in   1       beat is final of burst
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_sum    out  ACC_W   signed burst total
//  out_count  out  CNT_W   beats in burst (saturating)
//  out_ovf    out  1       burst overflowed accumulator (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, high): state=ACC, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0; in_ready=1 from cycle after reset drops.
//  - FSM ACC: in_ready=1, out_valid=0. Beat accepted when in_valid&in_ready.
//    acc <= acc + sext(in_data) to ACC_W; cnt <= cnt+1, saturating at 2^CNT_W-1 (no wrap).
//  - ACC, accepted beat with in_last=1: out_sum <= acc+sext(in_data), out_count <= cnt+1 (sat), out_ovf <= ovf|this-beat-ovf;
//    acc,cnt,ovf cleared; state -> OUT. out_valid rises the cycle after the last beat (latency 1).
//  - FSM OUT: in_ready=0, out_valid=1; out_sum/out_count/out_ovf held stable until out_ready.
//    out_valid&out_ready -> state ACC, out_valid=0 next cycle. Min burst period = beats+1 cycles.
//  - in_valid while in_ready=0: beat not consumed; upstream holds data (standard valid/ready, valid must not depend on ready).
//  - Single-beat burst (in_last on first beat): out_sum = sext(in_data), out_count=1.
//  - out_ready asserted in ACC: ignored.
//  - Reset mid-burst or while OUT: partial sum and pending result discarded, all state to reset values.
//  - Arithmetic two's complement; sign extension of in_data mandatory (0x8000_0000 contributes -2^31).
// CONFIGURATION
//  Macro MULT_16_SIGNED_ACCUM_SAT_EN:
//  - defined: each add clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets sticky burst ovf, reported on out_ovf.
//  - undefined: adds wrap modulo 2^ACC_W; out_ovf tied 0; no saturation logic synthesised.
// STRUCTURE
//  - Package mult_16_signed_pkg: PROD_W/ACC_W/CNT_W default localparams, state typedef {ACC, OUT}, sext helper function.
//  - One sub-module: mult_16_signed_sat_add (combinational ACC_W adder; outputs sum and ovf; clamps only under the macro).
//  - Top holds FSM, acc/cnt/ovf registers and output registers.
// TESTING
//  1 Burst of 3: 0x0000_0006, 0xFFFF_FFFE(-2), 0x0000_000A last, out_ready=1 -> out_sum=14, out_count=3, out_valid one cycle after beat 3.
//  2 Single beat 0x8000_0000 last -> out_sum = -2^31 sign-extended (0xFF_8000_0000 at ACC_W=40), count 1.
//  3 Backpressure: out_ready=0 for 5 cycles after result -> out_valid/out_sum stable, in_ready=0, upstream beats not consumed; release -> next burst accepted the cycle after.
//  4 Reset asserted after 2 beats of a burst -> no out_valid; next burst {5 last} gives out_sum=5, count 1.
//  5 ACC_W=33, two beats 0x7FFF_FFFF+0x7FFF_FFFF... +2 beats: with SAT_EN -> sum clamps to 2^32-1, out_ovf=1; without -> wrapped value, out_ovf=0.
//  6 CNT_W=2, burst of 5 beats value 1 -> out_sum=5, out_count=3 (saturated).

Source files
------------

// File: rtl/mult_16_signed_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mult_16_signed_pkg                                                |
// | Brief   : Shared widths, FSM state type and sign-extension helper for the   |
// |           mult_16_signed accumulator back-end.                              |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mult_16_signed_pkg;

  localparam int DEFAULT_PROD_W = 32;
  localparam int DEFAULT_ACC_W  = 40;
  localparam int DEFAULT_CNT_W  = 8;
  localparam int SEXT_MAX_W     = 128;

  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // Left-justify then arithmetic-shift back so bit from_w-1 fills the upper bits.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] value,
                                                 input int unsigned            from_w);
    logic signed [SEXT_MAX_W-1:0] shifted;
    shifted = $signed(value << (SEXT_MAX_W - from_w));
    return shifted >>> (SEXT_MAX_W - from_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_16_signed_sat_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mult_16_signed_sat_add                                            |
// | Brief   : Combinational signed ACC_W adder; clamps and flags overflow only  |
// |           when MULT_16_SIGNED_ACCUM_SAT_EN is defined, otherwise wraps.     |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mult_16_signed_sat_add
  import mult_16_signed_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw_sum;

  assign raw_sum = a + b;

`ifdef MULT_16_SIGNED_ACCUM_SAT_EN
  logic raw_ovf;

  // Signed overflow: operands agree in sign, result does not.
  assign raw_ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw_sum[ACC_W-1] != a[ACC_W-1]);

  always_comb begin
    sum = raw_sum;
    if (raw_ovf) begin
      sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign ovf = raw_ovf;
`else
  assign sum = raw_sum;
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/mult_16_signed_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mult_16_signed_accum                                              |
// | Brief   : Burst accumulator for signed products over valid/ready; emits the |
// |           burst total, saturating beat count and overflow flag.             |
// |           Optional clamp-on-overflow: MULT_16_SIGNED_ACCUM_SAT_EN.          |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mult_16_signed_accum
  import mult_16_signed_pkg::*;
#(
  parameter int PROD_W = DEFAULT_PROD_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic [SEXT_MAX_W-1:0] in_wide;
  logic [ACC_W-1:0]      in_ext;
  logic [ACC_W-1:0]      add_sum;
  logic                  add_ovf;
  logic [CNT_W-1:0]      cnt_inc;

  always_comb begin
    in_wide             = '0;
    in_wide[PROD_W-1:0] = in_data;
  end

  assign in_ext = ACC_W'(sext(in_wide, PROD_W));

  mult_16_signed_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (in_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Count holds at all-ones rather than wrapping back to zero.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (in_last) begin
            out_sum_d   = add_sum;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | add_ovf;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = OUT;
          end else begin
            acc_d = add_sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_ovf;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_16_signed_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mult_16_signed_accum                                           |
// | Brief   : Self-checking bench: vector table, hand sequences and random      |
// |           bursts against an arithmetic reference model.                     |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_mult_16_signed_accum;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [31:0] in_data;
  logic [39:0] out_sum;
  logic [7:0]  out_count;

  // Narrow accumulator instance (ACC_W=33)
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
  logic [31:0] b_in_data;
  logic [32:0] b_out_sum;
  logic [7:0]  b_out_count;

  // Narrow counter instance (CNT_W=2)
  logic        c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_ovf;
  logic [31:0] c_in_data;
  logic [39:0] c_out_sum;
  logic [1:0]  c_out_count;

  mult_16_signed_accum dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  mult_16_signed_accum #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  mult_16_signed_accum #(.PROD_W(32), .ACC_W(40), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_sum(c_out_sum), .out_count(c_out_count), .out_ovf(c_out_ovf)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int              n;
    logic [3:0][31:0] d;
    logic [39:0]     sum;
    int              cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int n, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input logic [39:0] sum, input int cnt);
    vecs[idx].n    = n;
    vecs[idx].d[0] = d0;
    vecs[idx].d[1] = d1;
    vecs[idx].d[2] = d2;
    vecs[idx].d[3] = d3;
    vecs[idx].sum  = sum;
    vecs[idx].cnt  = cnt;
  endtask

  // Present one beat and hold it until the stage takes it; returns 1 ns after
  // the accepting edge. out_ready is randomised while accumulating (must be ignored).
  task automatic send_beat(input logic [31:0] d, input logic last);
    int waited = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    out_ready = 1'($urandom_range(0, 1));
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk("beat accept timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [39:0] es, input int ec, input int hold);
    int waited = 0;
    logic [39:0] held;
    while (!out_valid && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, " out_sum"}, 64'(out_sum), 64'(es));
    chk({tag, " out_count"}, 64'(out_count), 64'(ec));
    chk({tag, " out_ovf"}, 64'(out_ovf), 64'd0);
    held = out_sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " held valid"}, 64'(out_valid), 64'd1);
      chk({tag, " held sum"}, 64'(out_sum), 64'(held));
      chk({tag, " in_ready in OUT"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint      s;
    longint      hi;
    logic        ov;
    logic [31:0] d;
    int          n;

    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_last = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_last = 1'b0; c_in_data = '0; c_out_ready = 1'b1;

    set_vec(0, 3, 32'h0000_0006, 32'hFFFF_FFFE, 32'h0000_000A, 32'h0, 40'd14, 3);
    set_vec(1, 1, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 40'hFF_8000_0000, 1);
    set_vec(2, 2, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 40'h0, 2);
    set_vec(3, 4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 40'h01_FFFF_FFFC, 4);
    set_vec(4, 4, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 40'hFE_0000_0000, 4);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_sum", 64'(out_sum), 64'd0);
    chk("reset out_count", 64'(out_count), 64'd0);
    chk("reset out_ovf", 64'(out_ovf), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);

    // Table-driven bursts; out_valid must rise right after the last beat
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        send_beat(vecs[v].d[k], k == vecs[v].n - 1);
        if (k < vecs[v].n - 1)
          chk($sformatf("vec%0d early valid", v), 64'(out_valid), 64'd0);
      end
      chk($sformatf("vec%0d latency", v), 64'(out_valid), 64'd1);
      collect($sformatf("vec%0d", v), vecs[v].sum, vecs[v].cnt, 0);
    end

    // Backpressure: result held, upstream beat waits, taken the cycle after release
    send_beat(32'h0000_0123, 1'b1);
    in_valid = 1'b1; in_data = 32'h0000_0055; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", 64'(out_valid), 64'd1);
      chk("bp sum", 64'(out_sum), 64'h123);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    collect("bp next", 40'h55, 1, 0);

    // Reset mid-burst discards the partial sum
    send_beat(32'd100, 1'b0);
    send_beat(32'd200, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midreset no valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    send_beat(32'd5, 1'b1);
    collect("after reset", 40'd5, 1, 0);

    // ACC_W=33 overflow: four beats of 0x7FFF_FFFF
    hi = 64'sd4294967295;
    s  = 0;
    ov = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = s + 64'sd2147483647;
`ifdef MULT_16_SIGNED_ACCUM_SAT_EN
      if (s > hi) begin
        s  = hi;
        ov = 1'b1;
      end
`endif
    end
    chk("b in_ready", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b1; b_in_data = 32'h7FFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      b_in_last = (i == 3);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0; b_in_last = 1'b0;
    chk("b out_valid", 64'(b_out_valid), 64'd1);
    chk("b out_sum", 64'(b_out_sum), 64'(s) & 64'h1_FFFF_FFFF);
    chk("b out_count", 64'(b_out_count), 64'd4);
    chk("b out_ovf", 64'(b_out_ovf), 64'(ov));

    // CNT_W=2: five beats of 1, count saturates at 3
    c_in_valid = 1'b1; c_in_data = 32'd1;
    for (int i = 0; i < 5; i++) begin
      c_in_last = (i == 4);
      @(posedge clk); #1;
    end
    c_in_valid = 1'b0; c_in_last = 1'b0;
    chk("c out_valid", 64'(c_out_valid), 64'd1);
    chk("c out_sum", 64'(c_out_sum), 64'd5);
    chk("c out_count", 64'(c_out_count), 64'd3);

    // Random bursts against plain signed arithmetic
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 6);
      s = 0;
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       d = 32'h8000_0000;
          1:       d = 32'h7FFF_FFFF;
          default: d = $urandom;
        endcase
        s = s + longint'($signed(d));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_beat(d, k == n - 1);
      end
      collect($sformatf("rand%0d", r), 40'(s), n, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
